// File: rtl/daccess_bridge.sv
// daccess_bridge: bridges the core's single-cycle data access requests onto a
// request/grant, variable-latency memory bus and returns one completion pulse
// per access.
//
// Optional feature: define DACCESS_TIMEOUT_EN to abort accesses stuck in
// CMD+WAIT for TIMEOUT_CYCLES cycles (sticky bus_err, 32'hDEAD_BEEF read data).
//
// Ports:
//   cpu_clk, cpu_rstn        clock, asynchronous active-low reset
//   daccess_ren/addr/wen/wdata   core request (sampled in IDLE only)
//   daccess_valid/rdata/wresp    core completion (read pulse, data, write pulse)
//   bus_req/we/addr/wdata        bus command, held until bus_gnt
//   bus_gnt/rvalid/rdata/bvalid  bus grant and completion
//   bus_err                      sticky abort flag (0 without the timeout)
module daccess_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic [3:0]  daccess_ren,
    input  logic [31:0] daccess_addr,
    input  logic [3:0]  daccess_wen,
    input  logic [31:0] daccess_wdata,
    output logic        daccess_valid,
    output logic [31:0] daccess_rdata,
    output logic        daccess_wresp,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_bvalid,
    output logic        bus_err
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 30;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("daccess_bridge: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            is_write_q, is_write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            req_c;
    logic            done_c;
    logic            abort_c;
    logic [1:0]      unused_addr_lsb;

    // Word-aligned bus: the byte offset is handled by the core.
    assign unused_addr_lsb = daccess_addr[1:0];

    assign req_c  = (|daccess_ren) | (|daccess_wen);
    assign done_c = (state_q == ST_WAIT) && (is_write_q ? bus_bvalid : bus_rvalid);

`ifdef DACCESS_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        busy_c;

    assign busy_c  = (state_q == ST_CMD) || (state_q == ST_WAIT);
    // A completion landing on the timeout cycle is a normal completion.
    assign abort_c = busy_c && (cnt_q == TMO_LAST) && !done_c;

    // Cycle counter for CMD+WAIT and the sticky error flag.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | abort_c;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (busy_c) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus_err = err_q;
`else
    assign abort_c = 1'b0;
    assign bus_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and command/response capture.
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    // A write strobe takes priority; a concurrent read is dropped.
                    is_write_d = |daccess_wen;
                    addr_d     = daccess_addr[31:2];
                    we_d       = daccess_wen;
                    wdata_d    = daccess_wdata;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (abort_c) begin
                    state_d = ST_RESP;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done_c) begin
                    if (!is_write_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = ST_RESP;
                end else if (abort_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_c && !is_write_q) begin
            rdata_d = 32'hDEAD_BEEF;
        end
    end

    // Latched command and returned read data.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // Outputs come from registers and state only.
    assign bus_req       = (state_q == ST_CMD);
    assign bus_we        = we_q;
    assign bus_addr      = {addr_q, 2'b00};
    assign bus_wdata     = wdata_q;
    assign daccess_rdata = rdata_q;
    assign daccess_valid = (state_q == ST_RESP) && !is_write_q;
    assign daccess_wresp = (state_q == ST_RESP) && is_write_q;

endmodule

// File: tb/tb_daccess_bridge.sv
// Directed bench for daccess_bridge: hand-computed vectors, one check task.
module tb_daccess_bridge;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic [3:0]  daccess_ren;
    logic [31:0] daccess_addr;
    logic [3:0]  daccess_wen;
    logic [31:0] daccess_wdata;
    logic        daccess_valid;
    logic [31:0] daccess_rdata;
    logic        daccess_wresp;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_bvalid;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;
    logic busy = 1'b0;

    daccess_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rstn      (cpu_rstn),
        .daccess_ren   (daccess_ren),
        .daccess_addr  (daccess_addr),
        .daccess_wen   (daccess_wen),
        .daccess_wdata (daccess_wdata),
        .daccess_valid (daccess_valid),
        .daccess_rdata (daccess_rdata),
        .daccess_wresp (daccess_wresp),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_bvalid    (bus_bvalid),
        .bus_err       (bus_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // The core is stalled while an access is in flight; it must not issue requests.
    always @(posedge cpu_clk) begin
        if (cpu_rstn && busy && ((|daccess_ren) || (|daccess_wen))) begin
            $display("FAIL stall_req: got request while busy, expected none");
            n_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access, entered and left on a negedge in IDLE. gnt_wait idle cycles
    // before grant; wrong_strobe adds one WAIT cycle with the other-type strobe.
    task automatic access(input string tag, input logic [3:0] ren, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int gnt_wait, input logic wrong_strobe,
                          input logic exp_write, input logic [3:0] exp_we,
                          input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
        daccess_ren   = ren;
        daccess_wen   = wen;
        daccess_addr  = addr;
        daccess_wdata = wdata;
        @(negedge cpu_clk);
        busy        = 1'b1;
        daccess_ren = '0;
        daccess_wen = '0;
        for (int i = 0; i <= gnt_wait; i++) begin
            chk({tag, ":req"},  32'(bus_req), 32'd1);
            chk({tag, ":we"},   32'(bus_we), 32'(exp_we));
            chk({tag, ":addr"}, bus_addr, exp_addr);
            if (exp_write) chk({tag, ":wdata"}, bus_wdata, wdata);
            bus_gnt = (i == gnt_wait);
            @(negedge cpu_clk);
        end
        bus_gnt = 1'b0;
        chk({tag, ":req_drop"}, 32'(bus_req), 32'd0);
        chk({tag, ":early"},    32'({daccess_valid, daccess_wresp}), 32'd0);
        if (wrong_strobe) begin
            bus_rvalid = !exp_write;
            bus_bvalid = exp_write;
            bus_rvalid = exp_write;
            bus_bvalid = !exp_write;
            bus_rdata  = 32'h5555_AAAA;
            @(negedge cpu_clk);
            bus_rvalid = 1'b0;
            bus_bvalid = 1'b0;
            chk({tag, ":ignored"}, 32'({daccess_valid, daccess_wresp}), 32'd0);
        end
        bus_rvalid = !exp_write;
        bus_bvalid = exp_write;
        bus_rdata  = rd;
        @(negedge cpu_clk);
        bus_rvalid = 1'b0;
        bus_bvalid = 1'b0;
        bus_rdata  = 32'h0;
        chk({tag, ":valid"}, 32'(daccess_valid), 32'(!exp_write));
        chk({tag, ":wresp"}, 32'(daccess_wresp), 32'(exp_write));
        chk({tag, ":rdata"}, daccess_rdata, exp_rdata);
        busy = 1'b0;
        @(negedge cpu_clk);
        chk({tag, ":one_pulse"}, 32'({daccess_valid, daccess_wresp}), 32'd0);
    endtask

    initial begin
        cpu_rstn      = 1'b0;
        daccess_ren   = '0;
        daccess_wen   = '0;
        daccess_addr  = '0;
        daccess_wdata = '0;
        bus_gnt       = 1'b0;
        bus_rvalid    = 1'b0;
        bus_bvalid    = 1'b0;
        bus_rdata     = '0;
        #1;
        chk("rst:req",   32'(bus_req), 32'd0);
        chk("rst:we",    32'(bus_we), 32'd0);
        chk("rst:addr",  bus_addr, 32'd0);
        chk("rst:wdata", bus_wdata, 32'd0);
        chk("rst:pulse", 32'({daccess_valid, daccess_wresp}), 32'd0);
        chk("rst:rdata", daccess_rdata, 32'd0);
        chk("rst:err",   32'(bus_err), 32'd0);
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);

        // Zero-wait read: req N+1, pulse N+3.
        access("rd0", 4'hF, 4'h0, 32'h0000_1C06, 32'h0, 32'h1122_3344, 0, 1'b0,
               1'b0, 4'h0, 32'h0000_1C04, 32'h1122_3344);
        // Write held 6 cycles by grant backpressure.
        access("wr_bp", 4'h0, 4'b0011, 32'h0000_2000, 32'h0000_ABCD, 32'h0, 5, 1'b0,
               1'b1, 4'b0011, 32'h0000_2000, 32'h1122_3344);
        // Back-to-back read then write; wrong-type strobes ignored.
        access("b2b_rd", 4'hF, 4'h0, 32'h0000_0043, 32'h0, 32'hCAFE_F00D, 1, 1'b1,
               1'b0, 4'h0, 32'h0000_0040, 32'hCAFE_F00D);
        access("b2b_wr", 4'h0, 4'b1100, 32'h0000_0044, 32'hFFEE_0000, 32'h0, 0, 1'b1,
               1'b1, 4'b1100, 32'h0000_0044, 32'hCAFE_F00D);
        // Read and write together: write wins.
        access("both", 4'hF, 4'hF, 32'h0000_3008, 32'h1234_5678, 32'h0, 0, 1'b0,
               1'b1, 4'hF, 32'h0000_3008, 32'hCAFE_F00D);

        // Reset while waiting for read data.
        daccess_ren   = 4'hF;
        daccess_addr  = 32'h0000_0080;
        daccess_wdata = 32'h0000_0077;
        @(negedge cpu_clk);
        daccess_ren = '0;
        chk("rstw:req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge cpu_clk);
        bus_gnt  = 1'b0;
        cpu_rstn = 1'b0;
        #1;
        chk("rstw:req",   32'(bus_req), 32'd0);
        chk("rstw:addr",  bus_addr, 32'd0);
        chk("rstw:wdata", bus_wdata, 32'd0);
        chk("rstw:rdata", daccess_rdata, 32'd0);
        @(negedge cpu_clk);
        cpu_rstn   = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0000_0099;
        @(negedge cpu_clk);
        bus_rvalid = 1'b0;
        chk("rstw:late", 32'({daccess_valid, daccess_wresp}), 32'd0);
        @(negedge cpu_clk);
        chk("rstw:late2", 32'(daccess_valid), 32'd0);
        chk("rstw:rdata2", daccess_rdata, 32'd0);

        access("post_rst", 4'hF, 4'h0, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 2, 1'b0,
               1'b0, 4'h0, 32'h0000_0010, 32'h0BAD_F00D);

`ifdef DACCESS_TIMEOUT_EN
        // Grant never arrives: abort after 8 cycles of bus_req.
        daccess_ren  = 4'hF;
        daccess_addr = 32'h0000_0500;
        @(negedge cpu_clk);
        daccess_ren = '0;
        for (int i = 0; i < 8; i++) begin
            chk("tmo:req", 32'(bus_req), 32'd1);
            @(negedge cpu_clk);
        end
        chk("tmo:req_drop", 32'(bus_req), 32'd0);
        chk("tmo:valid",    32'(daccess_valid), 32'd1);
        chk("tmo:rdata",    daccess_rdata, 32'hDEAD_BEEF);
        chk("tmo:err",      32'(bus_err), 32'd1);
        @(negedge cpu_clk);
        chk("tmo:one_pulse", 32'(daccess_valid), 32'd0);
        chk("tmo:err_sticky", 32'(bus_err), 32'd1);
`else
        chk("noerr", 32'(bus_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
